// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared constants for the opsum requantize/pack stage
package ppu_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int MULT_BITS  = 16;
  localparam int SHIFT_BITS = 5;

  // Saturation limits used by the requant arithmetic
  localparam int UINT8_MAX = 255;
  localparam int INT16_MAX = 32767;
  localparam int INT16_MIN = -32768;

endpackage

// File: rtl/requant_unit.sv
// rtl/requant_unit.sv - two-stage scale/round/shift/zero-point/clamp pipeline
module requant_unit #(
  parameter int DATA_BITS  = 32,
  parameter int MULT_BITS  = ppu_pkg::MULT_BITS,
  parameter int SHIFT_BITS = ppu_pkg::SHIFT_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_bypass,
  input  logic [MULT_BITS-1:0]  cfg_mult,
  input  logic [SHIFT_BITS-1:0] cfg_shift,
  input  logic [7:0]            cfg_zp,
  input  logic                  cfg_relu,
  input  logic                  in_valid,
  input  logic [DATA_BITS-1:0]  in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_BITS-1:0]  out_data,
  output logic                  out_last,
  input  logic                  out_ready
);
  import ppu_pkg::*;

  localparam int PROD_BITS = DATA_BITS + MULT_BITS + 1;
  localparam logic signed [PROD_BITS-1:0] R16_MAX = PROD_BITS'(INT16_MAX);
  localparam logic signed [PROD_BITS-1:0] R16_MIN = PROD_BITS'(INT16_MIN);
  localparam logic signed [17:0]          V_MAX   = 18'(UINT8_MAX);

  logic                        s1_valid;
  logic                        s1_last;
  logic                        s1_advance;
  logic signed [PROD_BITS-1:0] s1_prod;
  logic signed [PROD_BITS-1:0] in_ext;
  logic signed [PROD_BITS-1:0] mult_ext;
  logic signed [PROD_BITS-1:0] prod;
  logic signed [PROD_BITS-1:0] rnd;
  logic signed [PROD_BITS-1:0] r;
  logic signed [15:0]          r16;
  logic signed [17:0]          v;
  logic signed [17:0]          lo;
  logic [7:0]                  q;

  // S1 drains whenever S2 is empty or S2 is being consumed this cycle
  assign s1_advance = s1_valid & (!out_valid | out_ready);
  assign in_ready   = !s1_valid | s1_advance;

  // Multiplier is unsigned, so it is zero-extended before the signed multiply
  assign in_ext   = PROD_BITS'($signed(in_data));
  assign mult_ext = PROD_BITS'({1'b0, cfg_mult});
  assign prod     = in_ext * mult_ext;

  // Round half toward +inf, shift, saturate to int16, add zero point, clamp to uint8
  always_comb begin
    rnd = '0;
    if (cfg_shift != '0) rnd = PROD_BITS'(1) << (cfg_shift - SHIFT_BITS'(1));
    r = (s1_prod + rnd) >>> cfg_shift;
    if (r > R16_MAX)      r16 = 16'(INT16_MAX);
    else if (r < R16_MIN) r16 = 16'(INT16_MIN);
    else                  r16 = r[15:0];
    v  = {{2{r16[15]}}, r16} + {10'd0, cfg_zp};
    lo = cfg_relu ? {10'd0, cfg_zp} : 18'd0;
    if (v > V_MAX)   q = V_MAX[7:0];
    else if (v < lo) q = lo[7:0];
    else             q = v[7:0];
  end

  // S1 register: product (or raw psum in bypass) with its end-of-job tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_prod  <= cfg_bypass ? in_ext : prod;
      s1_last  <= in_last;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 register: finished byte (or raw word in bypass) waiting for the packer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= 1'b1;
      out_data  <= cfg_bypass ? s1_prod[DATA_BITS-1:0] : {{(DATA_BITS-8){1'b0}}, q};
      out_last  <= s1_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/opsum_requant_packer.sv
// rtl/opsum_requant_packer.sv - requantize PE opsums to uint8 and pack 4 per word
module opsum_requant_packer #(
  parameter int DATA_BITS  = 32,
  parameter int MULT_BITS  = ppu_pkg::MULT_BITS,
  parameter int SHIFT_BITS = ppu_pkg::SHIFT_BITS,
  parameter int CNT_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [MULT_BITS-1:0]  cfg_mult,
  input  logic [SHIFT_BITS-1:0] cfg_shift,
  input  logic [7:0]            cfg_zp,
  input  logic                  cfg_relu,
  input  logic                  cfg_bypass,
  input  logic [CNT_BITS-1:0]   cfg_count,
  input  logic [DATA_BITS-1:0]  psum_in,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  output logic [DATA_BITS-1:0]  out_data,
  output logic [3:0]            out_strb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  import ppu_pkg::*;

  logic [1:0]            state;
  logic [MULT_BITS-1:0]  mult_q;
  logic [SHIFT_BITS-1:0] shift_q;
  logic [7:0]            zp_q;
  logic                  relu_q;
  logic                  bypass_q;
  logic [CNT_BITS-1:0]   count_q;
  logic [CNT_BITS-1:0]   in_cnt;
  logic [1:0]            lane;
  logic                  run;
  logic                  ru_in_ready;
  logic                  take;
  logic                  take_last;
  logic                  ru_valid;
  logic [DATA_BITS-1:0]  ru_data;
  logic                  ru_last;
  logic                  pk_accept;
  logic                  handshake;

  assign run        = (state == RUN);
  assign psum_ready = run & ru_in_ready;
  assign take       = psum_valid & psum_ready;
  assign take_last  = (in_cnt + CNT_BITS'(1)) == count_q;
  // The packer register doubles as the output register: it can take a byte
  // unless a completed word is still waiting for the GLB.
  assign pk_accept  = !out_valid | out_ready;
  assign handshake  = out_valid & out_ready;
  assign done       = (state == DRAIN) & handshake & out_last;
  assign busy       = (state != IDLE);

  requant_unit #(
    .DATA_BITS  (DATA_BITS),
    .MULT_BITS  (MULT_BITS),
    .SHIFT_BITS (SHIFT_BITS)
  ) u_requant (
    .clk        (clk),
    .rst        (rst),
    .cfg_bypass (bypass_q),
    .cfg_mult   (mult_q),
    .cfg_shift  (shift_q),
    .cfg_zp     (zp_q),
    .cfg_relu   (relu_q),
    .in_valid   (psum_valid & run),
    .in_data    (psum_in),
    .in_last    (take_last),
    .in_ready   (ru_in_ready),
    .out_valid  (ru_valid),
    .out_data   (ru_data),
    .out_last   (ru_last),
    .out_ready  (pk_accept)
  );

  // Job FSM: latch config on load, count accepted psums, finish on last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mult_q   <= '0;
      shift_q  <= '0;
      zp_q     <= '0;
      relu_q   <= 1'b0;
      bypass_q <= 1'b0;
      count_q  <= '0;
      in_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_load) begin
            mult_q   <= cfg_mult;
            shift_q  <= cfg_shift;
            zp_q     <= cfg_zp;
            relu_q   <= cfg_relu;
            bypass_q <= cfg_bypass;
            count_q  <= (cfg_count == '0) ? CNT_BITS'(1) : cfg_count;
            in_cnt   <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (take) begin
            in_cnt <= in_cnt + CNT_BITS'(1);
            if (take_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Packer: place each byte in lane (index mod 4); emit at lane 3 or job end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_strb  <= 4'h0;
      out_last  <= 1'b0;
      lane      <= 2'd0;
    end else if (ru_valid && pk_accept) begin
      if (bypass_q) begin
        out_data  <= ru_data;
        out_strb  <= 4'hF;
        out_valid <= 1'b1;
        out_last  <= ru_last;
      end else begin
        if (lane == 2'd0) begin
          out_data <= {{(DATA_BITS-8){1'b0}}, ru_data[7:0]};
          out_strb <= 4'b0001;
        end else begin
          out_data[{lane, 3'b000} +: 8] <= ru_data[7:0];
          out_strb                      <= out_strb | (4'b0001 << lane);
        end
        out_valid <= (lane == 2'd3) | ru_last;
        out_last  <= ru_last;
        lane      <= ru_last ? 2'd0 : lane + 2'd1;
      end
    end else if (handshake) begin
      out_valid <= 1'b0;
      out_strb  <= 4'h0;
      out_last  <= 1'b0;
    end
  end

endmodule
